imem_fetch_responder: RTL and testbench

//   Instruction-side responder for the program counter. Takes the current PC address and

---
 rtl/imem_fetch_responder_pkg.sv | 18 +
 rtl/imem_fetch_responder_if.sv | 47 ++++
 rtl/imem_fetch_responder_imem_store.sv | 31 +++
 rtl/imem_fetch_responder.sv | 106 ++++++++++
 tb/tb_imem_fetch_responder.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared definitions for the instruction fetch responder and the PC it serves.
// Defaults here must stay in step with the PC register width.
package imem_fetch_responder_pkg;

    localparam int unsigned IMEM_ADDR_W = 4;
    localparam int unsigned IMEM_DATA_W = 16;
    localparam int unsigned IMEM_DEPTH  = 1 << IMEM_ADDR_W;

    localparam logic [IMEM_DATA_W-1:0] IMEM_HALT_WORD = '1;
    localparam logic [IMEM_DATA_W-1:0] IMEM_NOP_WORD  = '0;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch, program-load and status signals between the responder and its PC/loader.
// slave = responder side, master = PC register and program loader side.
interface imem_fetch_responder_if
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W
);

    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] next_pc;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_done;
    logic              halted;
    logic              prog_err;

    modport slave (
        input  pc_addr,
        input  prog_we,
        input  prog_addr,
        input  prog_data,
        input  prog_done,
        output next_pc,
        output instr,
        output instr_valid,
        output halted,
        output prog_err
    );

    modport master (
        output pc_addr,
        output prog_we,
        output prog_addr,
        output prog_data,
        output prog_done,
        input  next_pc,
        input  instr,
        input  instr_valid,
        input  halted,
        input  prog_err
    );

endinterface

// File: rtl/imem_fetch_responder_imem_store.sv
// Programmable instruction store: async clear to NOP, one write port, one
// combinational read port.
module imem_store
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-side responder: returns mem[pc_addr] one cycle later and steers
// next_pc (increment, hold, or park on a halt word).
module imem_fetch_responder
    import imem_fetch_responder_pkg::*;
#(
    parameter int unsigned             ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned             DATA_W    = IMEM_DATA_W,
    parameter int unsigned             DEPTH     = 1 << ADDR_W,
    parameter logic [DATA_W-1:0]       HALT_WORD = '1
) (
    input  logic                    clk,
    input  logic                    reset,
    imem_fetch_responder_if.slave   bus
);

    fetch_state_t      state;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] instr_q;
    logic              valid_q;
    logic              halted_q;
    logic              err_q;
    logic              store_we;
    logic              is_halt;
    logic [ADDR_W-1:0] next_pc;

    // Writes only commit in LOAD; elsewhere they just raise prog_err.
    assign store_we = bus.prog_we && (state == S_LOAD);

    imem_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .we    (store_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (bus.pc_addr),
        .rdata (rd_word)
    );

    assign is_halt = (rd_word == HALT_WORD);

    always_comb begin
        next_pc = bus.pc_addr;
        if (state == S_RUN && !is_halt) begin
            next_pc = bus.pc_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LOAD;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    valid_q <= 1'b0;
                    if (bus.prog_done) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.prog_we) begin
                        err_q <= 1'b1;
                    end
                    // A halt word leaves instr at its previous value.
                    if (is_halt) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        instr_q <= rd_word;
                        valid_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    valid_q <= 1'b0;
                    if (bus.prog_we) begin
                        err_q <= 1'b1;
                    end
                    if (bus.prog_done) begin
                        halted_q <= 1'b0;
                        state    <= S_LOAD;
                    end
                end
                default: begin
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                    state    <= S_LOAD;
                end
            endcase
        end
    end

    assign bus.next_pc     = next_pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.prog_err    = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed and randomized checks of imem_fetch_responder against a behavioural
// program-memory model, with the PC register closed around next_pc.
module tb_imem_fetch_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_fetch_responder_if #(.ADDR_W(4), .DATA_W(16)) bus();

    imem_fetch_responder #(
        .ADDR_W    (4),
        .DATA_W    (16),
        .DEPTH     (16),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // PC register shares the reset net with the responder
    always @(posedge clk or posedge reset) begin
        if (reset) bus.pc_addr <= '0;
        else       bus.pc_addr <= bus.next_pc;
    end

    int total = 0;
    int bad = 0;
    bit armed = 0;

    // Behavioural model: a program memory plus "running"/"stopped" flags
    logic [15:0] m_mem [16];
    logic [15:0] m_instr;
    bit          m_valid, m_err, m_running, m_stopped;
    int          m_pc;

    function automatic int m_next_pc();
        if (m_running && m_mem[m_pc] != 16'hFFFF) return (m_pc + 1) % 16;
        return m_pc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        m_instr = 16'h0000;
        m_valid = 0; m_err = 0; m_running = 0; m_stopped = 0; m_pc = 0;
    endtask

    task automatic model_edge();
        int np;
        logic [15:0] w;
        np = m_next_pc();
        w  = m_mem[m_pc];
        if (m_running) begin
            if (bus.prog_we) m_err = 1;
            if (w == 16'hFFFF) begin
                m_valid = 0; m_running = 0; m_stopped = 1;
            end else begin
                m_instr = w; m_valid = 1;
            end
        end else if (m_stopped) begin
            if (bus.prog_we) m_err = 1;
            m_valid = 0;
            if (bus.prog_done) m_stopped = 0;
        end else begin
            if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_data;
            if (bus.prog_done) m_running = 1;
            m_valid = 0;
        end
        m_pc = np;
    endtask

    always @(posedge clk) if (armed && !reset) model_edge();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("instr",       32'(bus.instr),       32'(m_instr));
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            chk("halted",      32'(bus.halted),      32'(m_stopped));
            chk("prog_err",    32'(bus.prog_err),    32'(m_err));
            chk("pc_addr",     32'(bus.pc_addr),     32'(m_pc));
            chk("next_pc",     32'(bus.next_pc),     32'(m_next_pc()));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit we, input logic [3:0] addr, input logic [15:0] data, input bit done);
        bus.prog_we = we; bus.prog_addr = addr; bus.prog_data = data; bus.prog_done = done;
    endtask

    task automatic idle();
        drive(0, 4'd0, 16'h0000, 0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        model_reset();
        armed = 1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] addr, input logic [15:0] data);
        drive(1, addr, data, 0);
        tick();
        idle();
    endtask

    task automatic start();
        drive(0, 4'd0, 16'h0000, 1);
        tick();
        idle();
    endtask

    logic [15:0] exp1 [4];
    logic [15:0] saved [16];
    logic [3:0]  pa;

    initial begin
        exp1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

        // 1: basic sequence and one-cycle fetch latency
        do_reset();
        chk("t1_reset_valid", 32'(bus.instr_valid), 32'd0);
        chk("t1_reset_instr", 32'(bus.instr), 32'd0);
        for (int i = 0; i < 4; i++) load(4'(i), exp1[i]);
        start();
        chk("t1_valid_at_entry", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_seq_instr", 32'(bus.instr), 32'(exp1[i]));
            chk("t1_seq_valid", 32'(bus.instr_valid), 32'd1);
        end

        // 2: wrap from 15 to 0
        do_reset();
        for (int a = 0; a < 16; a++) begin
            saved[a] = 16'($urandom_range(0, 16'hFFFE));
            load(4'(a), saved[a]);
        end
        start();
        for (int k = 0; k < 17; k++) begin
            tick();
            chk("t2_instr", 32'(bus.instr), 32'(saved[k % 16]));
            chk("t2_pc", 32'(bus.pc_addr), 32'((k + 1) % 16));
        end

        // 3: halt, then patch and rerun
        do_reset();
        load(4'd0, 16'h0101);
        load(4'd1, 16'h0202);
        load(4'd2, 16'hFFFF);
        start();
        tick();
        chk("t3_i0", 32'(bus.instr), 32'h0101);
        tick();
        chk("t3_i1", 32'(bus.instr), 32'h0202);
        repeat (6) tick();
        chk("t3_halted", 32'(bus.halted), 32'd1);
        chk("t3_valid", 32'(bus.instr_valid), 32'd0);
        chk("t3_pc", 32'(bus.pc_addr), 32'd2);
        chk("t3_next_pc", 32'(bus.next_pc), 32'd2);
        chk("t3_instr_kept", 32'(bus.instr), 32'h0202);
        start();
        load(4'd2, 16'h0303);
        start();
        repeat (6) tick();

        // 4: write during RUN is rejected and flagged
        do_reset();
        load(4'd5, 16'h1234);
        start();
        tick();
        tick();
        drive(1, 4'd5, 16'hABCD, 0);
        tick();
        idle();
        chk("t4_err", 32'(bus.prog_err), 32'd1);
        for (int k = 0; k < 20; k++) begin
            pa = bus.pc_addr;
            tick();
            if (pa == 4'd5) chk("t4_mem5", 32'(bus.instr), 32'h1234);
        end
        chk("t4_err_sticky", 32'(bus.prog_err), 32'd1);

        // 5: write and prog_done in the same cycle
        do_reset();
        drive(1, 4'd0, 16'h5A5A, 1);
        tick();
        idle();
        tick();
        chk("t5_instr", 32'(bus.instr), 32'h5A5A);
        chk("t5_valid", 32'(bus.instr_valid), 32'd1);

        // 6: asynchronous reset between clock edges
        do_reset();
        load(4'd0, 16'h00AA);
        load(4'd1, 16'h00BB);
        start();
        repeat (3) tick();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6_valid_async", 32'(bus.instr_valid), 32'd0);
        chk("t6_halted_async", 32'(bus.halted), 32'd0);
        chk("t6_instr_async", 32'(bus.instr), 32'd0);
        tick();
        reset = 1'b0;
        start();
        tick();
        tick();
        chk("t6_cleared_instr", 32'(bus.instr), 32'd0);
        chk("t6_cleared_valid", 32'(bus.instr_valid), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 30,
                      4'($urandom_range(0, 15)),
                      ($urandom_range(0, 99) < 15) ? 16'hFFFF : 16'($urandom),
                      $urandom_range(0, 99) < 10);
                tick();
            end
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
